clk_freq_monitor: RTL and testbench
===================================

Name: clk_freq_monitor

Overview:
- Single-clock frequency meter. Counts rising edges of an asynchronous input, e.g. a PLL output divided into fabric or the target-board clock, over a fixed gate window of system-clock cycles.
- Publishes the count once per window and reports in-range and locked status.
- Sits beside the clock-generation block so the trigger logic is held off until the measured clock is stable and within limits.

Parameters:
- GATE_CYCLES, 27000, gate window length in clk cycles (1 ms at 27 MHz, so count reads in kHz); must be >= 4
- CNT_W, 16, width of edge counter and thresholds
- LOCK_WINDOWS, 4, consecutive in-range windows required before locked asserts; must be >= 1

Ports:
- clk  input  1  system clock, 27 MHz
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  measurement enable, level-sensitive
- sig_in  input  1  asynchronous signal under measurement
- lo_thresh  input  CNT_W  inclusive lower bound for in_range, sampled at window end
- hi_thresh  input  CNT_W  inclusive upper bound for in_range, sampled at window end
- count  output  CNT_W  edge count of last completed window
- count_valid  output  1  one-cycle pulse when count updates
- overflow  output  1  last completed window saturated
- in_range  output  1  last completed window within limits and not overflowed
- locked  output  1  LOCK_WINDOWS consecutive in-range windows seen

Behaviour:
- Reset, asynchronous, active low. All outputs are 0. FSM goes to IDLE. Synchroniser flops, gate counter, edge counter, sticky overflow and lock counter are all 0.
- Input path: sig_in passes through a 2-FF synchroniser (s1, s2) and a history flop s3.
  - edge = s2 & ~s3, a single-cycle strobe.
  - sig_in rising to edge strobe takes 3 clk cycles.
- FSM states: IDLE, ARM, MEASURE.
- IDLE:
  - Counters are held at 0.
  - enable=1 -> ARM.
- ARM:
  - Lasts 2 cycles to flush the synchroniser. Edges during ARM are ignored.
  - Then -> MEASURE with gate_cnt = GATE_CYCLES-1 and edge_cnt = 0.
- MEASURE:
  - Each cycle, if edge, edge_cnt increments. It saturates at 2^CNT_W-1, and an edge arriving while saturated sets sticky ovf.
  - gate_cnt decrements each cycle.
  - In the cycle gate_cnt==0 (terminal cycle), an edge in that same cycle is included in the result. The same cycle registers:
    - count <= final value
    - overflow <= ovf
    - in_range <= (!ovf && lo_thresh <= final && final <= hi_thresh), unsigned compare
    - count_valid <= 1 for exactly one cycle
  - All of these outputs are visible the cycle after the terminal cycle.
  - Also in the terminal cycle, gate_cnt reloads to GATE_CYCLES-1 and edge_cnt/ovf clear. An edge in the next cycle counts into the new window. Windows are back-to-back with no dead time.
  - Window period is exactly GATE_CYCLES clk cycles.
- Lock logic, updated at each terminal cycle:
  - If the new in_range is 1, lock_cnt increments, saturating at LOCK_WINDOWS. Otherwise lock_cnt goes to 0.
  - locked = (lock_cnt == LOCK_WINDOWS), registered.
  - locked drops on the same cycle in_range drops.
- enable deasserted in any state:
  - Next state is IDLE. The partial window is discarded and no count_valid is issued.
  - locked, in_range and lock_cnt clear next cycle. count and overflow retain their last values.
- enable reasserted: a full ARM then MEASURE sequence runs. The first count_valid comes GATE_CYCLES+3 cycles after the enable rising edge.
- lo_thresh > hi_thresh: in_range is always 0. This is legal, not an error.
- Threshold changes mid-window take effect only at the next terminal cycle.
- Edge rate above clk/2 cannot be resolved. The count is undefined but must not corrupt the FSM.

Decomposition:
- Package clk_freq_monitor_pkg holds:
  - FSM state enum (IDLE, ARM, MEASURE)
  - Default constants GATE_CYCLES_DEF and LOCK_WINDOWS_DEF
- Sub-module sync_edge_det contains the synchroniser plus the rising-edge strobe. Parameter STAGES=2; ports clk, rst_n, d, q, rise. It is reused by other async inputs in the triggerer.

Test Plan:
- GATE_CYCLES=100, enable=1, sig_in period 10 clk, lo=8, hi=12 -> count_valid every 100 cycles, count=10, in_range=1; locked=1 after 4th valid.
- Same setup, sig_in stops after lock -> next count=0 (or partial), in_range=0, locked=0 in the same cycle.
- CNT_W=4, sig_in period 4 clk over 100-cycle gate -> count=15, overflow=1, in_range=0 even with hi=15.
- Single sig_in pulse aligned so its edge strobe lands in the terminal cycle -> count=1 in that window, count=0 in the next.
- enable dropped at cycle 50 of a window -> no count_valid, locked=0, count keeps its prior value. Re-enable -> first count_valid exactly GATE_CYCLES+3 cycles later.
- rst_n asserted mid-window while locked -> all outputs 0 immediately. After release with enable=1 -> normal ARM/MEASURE restart.

Source files
------------

// File: rtl/clk_freq_monitor_pkg.sv
// Shared types and default constants for the clock frequency monitor.
package clk_freq_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int GATE_CYCLES_DEF  = 27000;
  localparam int LOCK_WINDOWS_DEF = 4;
  localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input plus a one-cycle rising-edge strobe.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of an async input over back-to-back gate windows and
// reports count, overflow, in-range and locked status once per window.
module clk_freq_monitor
  import clk_freq_monitor_pkg::*;
#(
  parameter int GATE_CYCLES  = GATE_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int LOCK_WINDOWS = LOCK_WINDOWS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] lo_thresh,
  input  logic [CNT_W-1:0] hi_thresh,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             in_range,
  output logic             locked
);

  localparam int GW   = $clog2(GATE_CYCLES);
  localparam int LK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [LK_W-1:0]  LOCK_N    = LK_W'(LOCK_WINDOWS);

  logic sig_lvl_unused, rise;

  sync_edge_det #(.STAGES(2)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .q    (sig_lvl_unused),
    .rise (rise)
  );

  state_e           state_q, state_d;
  logic             arm_q, arm_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             in_range_q, in_range_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;

  // Result including any edge in the current cycle, so the terminal cycle counts.
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_ovf, fin_in;
  logic [LK_W-1:0]  lock_nxt;

  always_comb begin
    fin_cnt = edge_cnt_q;
    fin_ovf = ovf_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) fin_ovf = 1'b1;
      else                       fin_cnt = edge_cnt_q + 1'b1;
    end
    fin_in   = !fin_ovf && (lo_thresh <= fin_cnt) && (fin_cnt <= hi_thresh);
    lock_nxt = '0;
    if (fin_in) lock_nxt = (lock_cnt_q == LOCK_N) ? lock_cnt_q : lock_cnt_q + 1'b1;

    state_d    = state_q;
    arm_d      = arm_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;
    in_range_d = in_range_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;

    if (!enable) begin
      // Partial window is dropped; last count/overflow stay visible.
      state_d    = IDLE;
      arm_d      = 1'b0;
      gate_d     = '0;
      edge_cnt_d = '0;
      ovf_d      = 1'b0;
      in_range_d = 1'b0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          arm_d   = 1'b0;
        end
        ARM: begin
          arm_d = 1'b1;
          if (arm_q) begin
            state_d    = MEASURE;
            gate_d     = GATE_LAST;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
          end
        end
        MEASURE: begin
          if (gate_q == '0) begin
            count_d    = fin_cnt;
            overflow_d = fin_ovf;
            in_range_d = fin_in;
            valid_d    = 1'b1;
            lock_cnt_d = lock_nxt;
            locked_d   = (lock_nxt == LOCK_N);
            gate_d     = GATE_LAST;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
          end else begin
            gate_d     = gate_q - 1'b1;
            edge_cnt_d = fin_cnt;
            ovf_d      = fin_ovf;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      in_range_q <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      in_range_q <= in_range_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign overflow    = overflow_q;
  assign in_range    = in_range_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Randomised scoreboard bench for clk_freq_monitor with a window-level reference model.
module tb_clk_freq_monitor;

  localparam int G     = 100;
  localparam int CW    = 4;
  localparam int LW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] lo_thresh = '0;
  logic [CW-1:0] hi_thresh = '0;
  logic [CW-1:0] count;
  logic          count_valid, overflow, in_range, locked;

  clk_freq_monitor #(.GATE_CYCLES(G), .CNT_W(CW), .LOCK_WINDOWS(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .lo_thresh  (lo_thresh),
    .hi_thresh  (hi_thresh),
    .count      (count),
    .count_valid(count_valid),
    .overflow   (overflow),
    .in_range   (in_range),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct { int cnt; int ovf; int inr; } res_t;
  res_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the input is seen through a 2-cycle synchroniser, so a
  // rise between samples k-1 and k lands in the window that owns clock edge k+2.
  // After enable is seen, 3 edges go to arming; then windows of G edges each.
  int run = 0, cnt = 0, ovf = 0, consec = 0;
  int h1 = 0, h2 = 0, h3 = 0;
  int exp_count = 0, exp_ovf = 0, exp_inr = 0, exp_locked = 0;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        run = 0; cnt = 0; ovf = 0; consec = 0; h1 = 0; h2 = 0; h3 = 0;
        exp_count = 0; exp_ovf = 0; exp_inr = 0; exp_locked = 0;
      end else begin
        int e;
        e = (h2 == 1 && h3 == 0) ? 1 : 0;
        if (!enable) begin
          run = 0; cnt = 0; ovf = 0; consec = 0; exp_inr = 0; exp_locked = 0;
        end else begin
          run++;
          if (run >= 4) begin
            if (e == 1) begin
              if (cnt == MAXC) ovf = 1;
              else cnt++;
            end
            if ((run - 4) % G == G - 1) begin
              res_t r;
              r.cnt = cnt;
              r.ovf = ovf;
              r.inr = (ovf == 0 && int'(lo_thresh) <= cnt && cnt <= int'(hi_thresh)) ? 1 : 0;
              exp_q.push_back(r);
              consec     = r.inr ? consec + 1 : 0;
              exp_count  = r.cnt;
              exp_ovf    = r.ovf;
              exp_inr    = r.inr;
              exp_locked = (consec >= LW) ? 1 : 0;
              cnt = 0;
              ovf = 0;
            end
          end else begin
            cnt = 0;
            ovf = 0;
          end
        end
        h3 = h2; h2 = h1; h1 = int'(sig_in);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (count_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 1, 0);
          end else begin
            res_t r;
            r = exp_q.pop_front();
            chk("win_count", int'(count), r.cnt);
            chk("win_overflow", int'(overflow), r.ovf);
            chk("win_in_range", int'(in_range), r.inr);
          end
        end else if (exp_q.size() != 0) begin
          chk("missing_valid", 0, 1);
          exp_q.delete();
        end
        chk("locked", int'(locked), exp_locked);
        chk("in_range", int'(in_range), exp_inr);
        chk("count", int'(count), exp_count);
        chk("overflow", int'(overflow), exp_ovf);
      end
    end
  end

  int ph = 0;

  task automatic run_sig(int period, int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      sig_in = (period > 0) ? (((ph % period) < (period / 2)) ? 1'b1 : 1'b0) : 1'b0;
      ph++;
    end
  endtask

  task automatic wait_valid(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (count_valid) return;
    end
    chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_valid"}, int'(count_valid), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_in_range"}, int'(in_range), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin : stim
    int n;
    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal clock: 10 edges per window, expected to lock after 4 windows.
    lo_thresh = 4'd8; hi_thresh = 4'd12; enable = 1'b1;
    run_sig(10, 6 * G + 20);
    chk("locked_after_nominal", int'(locked), 1);

    // Input stops: in_range and locked must fall together.
    run_sig(0, 2 * G);
    chk("unlocked_after_stop", int'(locked), 0);

    // Too many edges for a 4-bit counter.
    hi_thresh = 4'd15;
    run_sig(4, 3 * G);

    // Inverted thresholds are legal and never in range.
    lo_thresh = 4'd12; hi_thresh = 4'd3;
    run_sig(6, 2 * G);

    // Single pulse whose strobe lands in the terminal cycle of the first window.
    lo_thresh = 4'd1; hi_thresh = 4'd1;
    enable = 1'b0; sig_in = 1'b0;
    run_sig(0, 3);
    enable = 1'b1;
    for (int i = 0; i < 2 * G + 10; i++) begin
      @(posedge clk);
      #1 sig_in = (i == G - 1) ? 1'b1 : 1'b0;
    end

    // Lock, then drop enable mid-window and check the restart latency.
    lo_thresh = 4'd8; hi_thresh = 4'd12;
    run_sig(10, 5 * G);
    wait_valid(2 * G);
    run_sig(10, 50);
    enable = 1'b0;
    run_sig(10, 30);
    chk("locked_after_disable", int'(locked), 0);
    n = 0;
    enable = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 3 * G; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (count_valid) break;
    end
    chk("reenable_latency", n, G + 3);

    // Reset mid-window while locked.
    run_sig(10, 5 * G + 40);
    chk("locked_before_reset", int'(locked), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    run_sig(10, 3);
    rst_n = 1'b1;
    run_sig(10, 3 * G);

    // Randomised segments: rates, thresholds, enable drops, toggling noise.
    for (int s = 0; s < 12; s++) begin
      lo_thresh = 4'($urandom_range(0, 15));
      hi_thresh = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        run_sig(0, $urandom_range(1, 20));
        enable = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk);
          #1 sig_in = 1'($urandom_range(0, 1));
        end
      end else begin
        run_sig($urandom_range(2, 24), $urandom_range(50, 350));
      end
    end
    run_sig(0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
